shift_reg2d_ctrl: RTL and testbench
===================================

# shift_reg2D_ctrl

Sequencing and arbitration controller for the 4-bit × 16-entry 2D shift register. It shares the register's single input port between two requesters (A, B) using round-robin arbitration and a req/grant handshake. It drives the register's shift enable and input data, and tracks how many valid entries have been shifted in. When 16 entries have been loaded it freezes the register and raises a frame-complete flag until the consumer acknowledges; a flush command clears the register by shifting in zeros.

## Interface
- WIDTH, 4, data width of one shift-register entry
- DEPTH, 16, number of entries (frame length)
- CNT_W, 5, width of fill counter (must hold 0..DEPTH)

- CLK  in  1  system clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- REQ_A  in  1  requester A has a sample; held until granted
- DATA_A  in  WIDTH  requester A sample, stable while REQ_A high
- GNT_A  out  1  combinational grant to A; transfer when REQ_A && GNT_A at rising edge
- REQ_B / DATA_B / GNT_B  same as A, for requester B
- FRAME_ACK  in  1  consumer has read OUT_0..OUT_15; honoured only in HOLD
- FLUSH  in  1  single-cycle command to clear the register
- SHIFT_EN  out  1  registered shift enable to the shift register
- SHIFT_DATA  out  WIDTH  registered data to the shift register IN
- FILL  out  CNT_W  registered count of valid entries, 0..DEPTH
- FRAME_DONE  out  1  registered; high while frame is complete and frozen

## Operation
- One clock; reset is asynchronous and active-low.
- Reset values: state RUN, SHIFT_EN=0, SHIFT_DATA=0, FILL=0, FRAME_DONE=0, round-robin pointer LAST=B (A wins the first tie), flush counter=0. GNT_A and GNT_B are forced 0 while RST_N is low.
- States and transitions:
  - RUN: grants enabled.
  - RUN → HOLD: when an accepted transfer makes FILL reach DEPTH.
  - RUN → FLUSH: when FLUSH is sampled high.
  - HOLD: grants forced 0 and SHIFT_EN=0, so the register is frozen. FRAME_DONE=1.
  - HOLD → RUN: on FRAME_ACK. FILL←0 and FRAME_DONE←0 at the same edge.
  - HOLD → FLUSH: when FLUSH is sampled high.
  - FLUSH: grants forced 0. SHIFT_EN=1 and SHIFT_DATA=0 for exactly DEPTH consecutive cycles. FILL←0 and FRAME_DONE←0 at the entry edge. Returns to RUN after the DEPTH-th shift cycle.
  - FLUSH sampled during FLUSH: ignored; the count does not restart.
- Arbitration (RUN only, combinational):
  - Only one requester active: it is granted.
  - Both active: grant the one that is not LAST.
  - LAST updates on every accepted transfer.
  - At most one grant per cycle.
- Transfer at edge k (RUN, REQ_x && GNT_x):
  - SHIFT_DATA←DATA_x and SHIFT_EN←1.
  - FILL←FILL+1, saturating at DEPTH.
  - With no transfer, SHIFT_EN←0 and SHIFT_DATA holds its last value.
- Priority within one cycle: FLUSH > FRAME_ACK > requests.
  - FLUSH in RUN blocks that cycle's grants, so no transfer occurs.
- FRAME_ACK sampled in RUN or FLUSH: ignored.
- Arithmetic: FILL is unsigned, never exceeds DEPTH, never wraps. The flush counter counts 0..DEPTH-1.

## Timing
- Grant is combinational from REQ, state and LAST in the same cycle; there are no wait cycles in RUN.
- Acceptance edge k → SHIFT_EN high during cycle k+1 → the shift register captures at edge k+1. Latency from accept to capture is 1 cycle.
- Back-to-back transfers: one per cycle, sustained. Two requesters that both stay active alternate A, B, A, B…
- The 16th accept at edge k: FILL=16, state HOLD and FRAME_DONE=1, all from edge k. GNT is 0 from cycle k+1. SHIFT_EN for the 16th sample is still high in cycle k+1.
- FRAME_ACK sampled at edge m in HOLD: FILL=0, FRAME_DONE=0 and RUN from edge m. Grants are possible in cycle m+1.
- FLUSH sampled at edge f: SHIFT_EN=1 and SHIFT_DATA=0 in cycles f+1..f+DEPTH. Grants are possible from cycle f+DEPTH+1.
- Reset asserted mid-operation (any state): all outputs immediately return to reset values, asynchronously. A pending transfer in that cycle is lost. The first grant is possible in the first cycle after RST_N deasserts.

## Test plan
- Reset: hold RST_N=0 with REQ_A=1 -> GNT_A=0, SHIFT_EN=0, FILL=0, FRAME_DONE=0. Assert RST_N=0 mid-frame with FILL=7 -> FILL=0 without waiting for a clock edge.
- Single requester A sends 1..16 on consecutive cycles -> SHIFT_EN high for 16 cycles, each one lagging its accept by 1, with SHIFT_DATA 1..16 mod 16. FILL=16 and FRAME_DONE=1 after the 16th accept. GNT_A=0 while REQ_A is held.
- Both requesters held, A=0xA, B=0xB -> grants alternate A, B, A, B starting with A. SHIFT_DATA sequence is A,B,A,B…; the frame completes after 16 accepts, 8 from each.
- In HOLD, pulse FRAME_ACK together with REQ_B=1 -> no grant that cycle. Next cycle GNT_B=1, and FILL goes 0→1 on that accept.
- FLUSH pulsed with FILL=5 and REQ_A=1 in the same cycle -> no grant, FILL=0. SHIFT_EN=1 with SHIFT_DATA=0 for exactly 16 cycles. A second FLUSH mid-flush is ignored. GNT_A returns the cycle after the flush ends.
- FLUSH and FRAME_ACK together in HOLD -> the FLUSH path is taken: 16 zero shifts, FRAME_DONE=0 from the entry edge.

Source files
------------

// File: rtl/shift_reg2d_ctrl.sv
// Sequencing/arbitration controller for a WIDTH x DEPTH 2D shift register.
// Round-robin shares the single input port between requesters A and B, then freezes on a full frame.
module shift_reg2d_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_b,
  input  logic             frame_ack,
  input  logic             flush,
  output logic             shift_en,
  output logic [WIDTH-1:0] shift_data,
  output logic [CNT_W-1:0] fill,
  output logic             frame_done
);

  // state    | meaning
  // ST_RUN   | grants enabled, accepted samples shift in
  // ST_HOLD  | frame complete, register frozen until frame_ack
  // ST_FLUSH | DEPTH zero shifts in progress, grants blocked
  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_FLUSH} state_t;

  localparam int FC_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(DEPTH - 1);
  localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(DEPTH - 1);

  state_t          state;
  logic            last_b;
  logic [FC_W-1:0] flush_cnt;
  logic            run_ok;
  logic            pick_a;

  // Flush in RUN blocks that cycle's grants so no transfer races the clear.
  always_comb begin
    run_ok = rst_n && (state == ST_RUN) && !flush;
    pick_a = req_a && (!req_b || last_b);
    gnt_a  = run_ok && pick_a;
    gnt_b  = run_ok && req_b && !pick_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      shift_en   <= 1'b0;
      shift_data <= '0;
      fill       <= '0;
      frame_done <= 1'b0;
      last_b     <= 1'b1;
      flush_cnt  <= '0;
    end else if (flush && (state != ST_FLUSH)) begin
      state      <= ST_FLUSH;
      shift_en   <= 1'b1;
      shift_data <= '0;
      fill       <= '0;
      frame_done <= 1'b0;
      flush_cnt  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (gnt_a || gnt_b) begin
            shift_en   <= 1'b1;
            shift_data <= gnt_a ? data_a : data_b;
            last_b     <= gnt_b;
            if (fill >= FILL_LAST) begin
              fill       <= FILL_FULL;
              state      <= ST_HOLD;
              frame_done <= 1'b1;
            end else begin
              fill <= fill + CNT_W'(1);
            end
          end else begin
            shift_en <= 1'b0;
          end
        end
        ST_HOLD: begin
          shift_en <= 1'b0;
          if (frame_ack) begin
            state      <= ST_RUN;
            fill       <= '0;
            frame_done <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == FC_LAST) begin
            state    <= ST_RUN;
            shift_en <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + FC_W'(1);
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg2d_ctrl.sv
// Bench for shift_reg2d_ctrl: vector table, directed corner sequences and
// randomized traffic checked against a frame-level behavioural model.
module tb_shift_reg2d_ctrl;
  localparam int WIDTH = 4;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  localparam int M_RUN   = 0;
  localparam int M_HOLD  = 1;
  localparam int M_FLUSH = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_a = 1'b0, req_b = 1'b0;
  logic [WIDTH-1:0] data_a = '0, data_b = '0;
  logic             gnt_a, gnt_b;
  logic             frame_ack = 1'b0, flush = 1'b0;
  logic             shift_en;
  logic [WIDTH-1:0] shift_data;
  logic [CNT_W-1:0] fill;
  logic             frame_done;

  shift_reg2d_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b),
    .frame_ack(frame_ack), .flush(flush),
    .shift_en(shift_en), .shift_data(shift_data),
    .fill(fill), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  bit s_ga, s_gb;

  // model: frame mode, remaining zero shifts, fill, and who was served last
  int       m_mode;
  int       m_zeros;
  int       m_fill;
  bit       m_last_b;
  bit       m_en;
  bit       m_done;
  bit [3:0] m_data;

  typedef struct {
    logic ra; logic [3:0] da; logic rb; logic [3:0] db; logic ack; logic fl;
    logic ega; logic egb; logic een; logic [3:0] edat; logic [4:0] efill; logic edone;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_zeros = 0; m_fill = 0; m_last_b = 1'b1;
    m_en = 1'b0; m_done = 1'b0; m_data = 4'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b0; frame_ack = 1'b0; flush = 1'b0;
    #3;
    chk("rst_gnt_a", int'(gnt_a), 0);
    chk("rst_shift_en", int'(shift_en), 0);
    chk("rst_fill", int'(fill), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_shift_data", int'(shift_data), 0);
    @(posedge clk); #1;
    chk("rst_gnt_a_edge", int'(gnt_a), 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic ra, input logic [3:0] da, input logic rb,
                      input logic [3:0] db, input logic ack, input logic fl,
                      input bit use_model);
    bit ea, eb;
    req_a = ra; data_a = da; req_b = rb; data_b = db; frame_ack = ack; flush = fl;
    #1;
    ea = 1'b0; eb = 1'b0;
    if (m_mode == M_RUN && !fl) begin
      if (ra && rb) begin ea = m_last_b; eb = !m_last_b; end
      else begin ea = ra; eb = rb; end
    end
    s_ga = gnt_a; s_gb = gnt_b;
    if (use_model) begin
      chk("gnt_a", int'(gnt_a), int'(ea));
      chk("gnt_b", int'(gnt_b), int'(eb));
    end
    if (gnt_a && ra) cnt_a++;
    if (gnt_b && rb) cnt_b++;
    if (fl && m_mode != M_FLUSH) begin
      m_mode = M_FLUSH; m_zeros = DEPTH; m_en = 1'b1; m_data = 4'h0;
      m_fill = 0; m_done = 1'b0;
    end else if (m_mode == M_FLUSH) begin
      m_zeros--;
      m_en = (m_zeros != 0);
      if (m_zeros == 0) m_mode = M_RUN;
    end else if (m_mode == M_HOLD) begin
      m_en = 1'b0;
      if (ack) begin m_mode = M_RUN; m_fill = 0; m_done = 1'b0; end
    end else if (ea || eb) begin
      m_en = 1'b1;
      m_data = ea ? da : db;
      m_last_b = eb;
      m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH;
      if (m_fill == DEPTH) begin m_mode = M_HOLD; m_done = 1'b1; end
    end else begin
      m_en = 1'b0;
    end
    @(posedge clk); #1;
    if (use_model) begin
      chk("shift_en", int'(shift_en), int'(m_en));
      chk("shift_data", int'(shift_data), int'(m_data));
      chk("fill", int'(fill), m_fill);
      chk("frame_done", int'(frame_done), int'(m_done));
    end
  endtask

  initial begin
    int zero_shifts;
    //        ra da    rb db    ack fl  ga gb en dat   fill  done
    tbl[0] = '{1, 4'h3, 0, 4'h0, 0, 0,  1, 0, 1, 4'h3, 5'd1, 0};
    tbl[1] = '{1, 4'h5, 1, 4'h9, 0, 0,  0, 1, 1, 4'h9, 5'd2, 0};
    tbl[2] = '{1, 4'h5, 1, 4'h9, 0, 0,  1, 0, 1, 4'h5, 5'd3, 0};
    tbl[3] = '{0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 0, 4'h5, 5'd3, 0};
    tbl[4] = '{0, 4'h0, 1, 4'h7, 0, 0,  0, 1, 1, 4'h7, 5'd4, 0};
    tbl[5] = '{1, 4'h1, 1, 4'h2, 0, 1,  0, 0, 1, 4'h0, 5'd0, 0};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].ra, tbl[i].da, tbl[i].rb, tbl[i].db, tbl[i].ack, tbl[i].fl, 1'b0);
      chk($sformatf("tbl%0d_gnt_a", i), int'(s_ga), int'(tbl[i].ega));
      chk($sformatf("tbl%0d_gnt_b", i), int'(s_gb), int'(tbl[i].egb));
      chk($sformatf("tbl%0d_shift_en", i), int'(shift_en), int'(tbl[i].een));
      chk($sformatf("tbl%0d_shift_data", i), int'(shift_data), int'(tbl[i].edat));
      chk($sformatf("tbl%0d_fill", i), int'(fill), int'(tbl[i].efill));
      chk($sformatf("tbl%0d_frame_done", i), int'(frame_done), int'(tbl[i].edone));
    end
    for (int i = 0; i < 17; i++) step(0, 4'h0, 0, 4'h0, 0, 0, 1'b1);

    // asynchronous reset in the middle of a frame
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 4'(i + 1), 0, 4'h0, 0, 0, 1'b1);
    chk("mid_fill7", int'(fill), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_fill", int'(fill), 0);
    chk("async_shift_en", int'(shift_en), 0);
    chk("async_gnt_a", int'(gnt_a), 0);

    // single requester fills a frame, then ack with a B request waiting
    do_reset();
    for (int i = 1; i <= 16; i++) step(1, 4'(i), 0, 4'h0, 0, 0, 1'b1);
    chk("full_fill", int'(fill), 16);
    chk("full_done", int'(frame_done), 1);
    step(1, 4'h5, 0, 4'h0, 0, 0, 1'b1);
    step(1, 4'h5, 0, 4'h0, 0, 0, 1'b1);
    step(0, 4'h0, 1, 4'hC, 1, 0, 1'b1);
    step(0, 4'h0, 1, 4'hC, 0, 0, 1'b1);
    chk("after_ack_fill", int'(fill), 1);

    // both requesters held: strict alternation, 8 each
    do_reset();
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 16; i++) step(1, 4'hA, 1, 4'hB, 0, 0, 1'b1);
    chk("alt_cnt_a", cnt_a, 8);
    chk("alt_cnt_b", cnt_b, 8);
    chk("alt_done", int'(frame_done), 1);

    // flush at fill 5 with A requesting; second flush mid-way is ignored
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 4'h3, 0, 4'h0, 0, 0, 1'b1);
    zero_shifts = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 4'h3, 0, 4'h0, 0, (i == 0 || i == 6), 1'b1);
      if (shift_en && shift_data == 4'h0) zero_shifts++;
    end
    chk("flush_zero_shifts", zero_shifts, 16);

    // flush together with ack while holding a full frame
    do_reset();
    for (int i = 0; i < 16; i++) step(0, 4'h0, 1, 4'(i), 0, 0, 1'b1);
    step(0, 4'h0, 0, 4'h0, 1, 1, 1'b1);
    chk("flush_ack_done", int'(frame_done), 0);
    for (int i = 0; i < 17; i++) step(0, 4'h0, 0, 4'h0, 0, 0, 1'b1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 59) == 0), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
